ls_down_timer: RTL
==================

LS_DOWN_TIMER -- requirements
Module: ls_down_timer

Interface
REQ-001 Parameter: WIDTH, default 16, counter/reload width in bits, legal range 2..32.
REQ-002 cp  input  1  clock, all state changes on rising edge.
REQ-003 sr_b  input  1  reset, asynchronous, active-low.
REQ-004 p  input  WIDTH  parallel load value.
REQ-005 pe_b  input  1  synchronous parallel load, active-low.
REQ-006 cep  input  1  count enable, parallel.
REQ-007 cet  input  1  count enable, trickle.
REQ-008 mode  input  1  0 = one-shot, 1 = auto-reload; sampled each cycle.
REQ-009 start  input  1  synchronous start/restart strobe, active-high.
REQ-010 stop  input  1  synchronous halt strobe, active-high.
REQ-011 q  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle per expiry.
REQ-013 busy  output  1  high exactly while state is RUN.

Function
REQ-014 Internal state: count register (drives q), reload register rl (WIDTH), FSM {IDLE, RUN, DONE}, tc flop.
REQ-015 Per-edge priority, highest first: pe_b low > stop > start > count step; only the highest active action occurs.
REQ-016 pe_b low (any state): q <= p, rl <= p, state <= IDLE, tc <= 0.
REQ-017 stop high, state RUN: state <= IDLE, q held, tc <= 0; stop in IDLE/DONE: no effect.
REQ-018 start high, state IDLE or DONE, q != 0: state <= RUN, q held, tc <= 0.
REQ-019 start high, state IDLE or DONE, q == 0: state <= DONE, tc <= 1 for one cycle, q stays 0.
REQ-020 start high, state RUN: restart, q <= rl, state stays RUN, tc <= 0.
REQ-021 RUN with cep & cet high and q > 1: q <= q - 1, tc <= 0.
REQ-022 RUN with cep & cet high and q == 1, mode 0: q <= 0, state <= DONE, tc <= 1.
REQ-023 RUN with cep & cet high and q == 1, mode 1: q <= rl, state stays RUN, tc <= 1; period = rl enabled cycles.
REQ-024 RUN, mode 1, rl == 1: tc high on every enabled cycle, q stays 1.
REQ-025 RUN, mode 1, rl == 0 and q == 1: q <= 0, state <= DONE, tc <= 1 (one-shot fallback, no reload to 0).
REQ-026 RUN with cep or cet low: q, state held, tc <= 0.
REQ-027 tc never high for two consecutive cycles except under REQ-024.
REQ-028 Arithmetic is unsigned modulo 2^WIDTH; q never wraps below 0 (decrement from 0 never occurs).
REQ-029 DONE holds q == 0 until pe_b or start; cep/cet ignored outside RUN.
REQ-030 busy = (state == RUN), decoded from the registered state.

Reset
REQ-031 sr_b low asynchronously forces q = 0, rl = 0, state = IDLE, tc = 0, busy = 0 regardless of cp.
REQ-032 Reset asserted mid-RUN aborts the count with no tc pulse; after release the block waits in IDLE.
REQ-033 After sr_b rises, the first rising edge of cp is processed normally per REQ-015.

Verification
REQ-034 WIDTH=16, pe_b low with p=5, start, mode 0, cep=cet=1 -> q 5,4,3,2,1,0; tc high one cycle with q=0; busy falls same edge; state DONE.
REQ-035 p=3, mode 1, enables held high for 10 cycles after start -> q 3,2,1,3,2,1,3,...; tc pulses every 3rd cycle coincident with reload.
REQ-036 p=4, start, cet toggles 1,0,1,0 -> q decrements only on cet=1 cycles; tc stays 0 until q reaches 0.
REQ-037 Running at q=2, start and stop both high -> stop wins, state IDLE, q=2, busy=0, no tc.
REQ-038 Load p=0 then start -> tc high one cycle next edge, state DONE, busy never asserts.
REQ-039 Running at q=7, sr_b pulsed low between clock edges -> q=0, busy=0, tc=0 immediately; no tc after release.

Source files
------------

// File: rtl/ls_down_timer.sv
// ls_down_timer: loadable down-counting timer with one-shot and auto-reload modes.
//
// Ports:
//   cp    - clock, all state changes on the rising edge
//   sr_b  - asynchronous active-low reset
//   p     - parallel load value (also becomes the reload value)
//   pe_b  - synchronous parallel load, active-low, highest priority
//   cep   - count enable (parallel)
//   cet   - count enable (trickle); counting needs cep & cet
//   mode  - 0 = one-shot, 1 = auto-reload
//   start - start / restart strobe
//   stop  - halt strobe, only meaningful while running
//   q     - current count (registered)
//   tc    - terminal-count pulse (registered), one cycle per expiry
//   busy  - high while the timer is running
module ls_down_timer #(
  parameter int WIDTH = 16
) (
  input  logic             cp,
  input  logic             sr_b,
  input  logic [WIDTH-1:0] p,
  input  logic             pe_b,
  input  logic             cep,
  input  logic             cet,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] rl_r, rl_s;
  logic             tc_r, tc_s;

  // State, count, reload and tc registers.
  always_ff @(posedge cp or negedge sr_b) begin
    if (!sr_b) begin
      state_r <= IDLE;
      count_r <= ZERO;
      rl_r    <= ZERO;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      rl_r    <= rl_s;
      tc_r    <= tc_s;
    end
  end

  // Next-state logic: load > stop (only while running) > start > count step.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    rl_s    = rl_r;
    tc_s    = 1'b0;
    if (!pe_b) begin
      count_s = p;
      rl_s    = p;
      state_s = IDLE;
    end else if (stop && (state_r == RUN)) begin
      state_s = IDLE;
    end else if (start) begin
      if (state_r == RUN) begin
        count_s = rl_r;
      end else if (count_r == ZERO) begin
        // Nothing to count: expire immediately without ever entering RUN.
        state_s = DONE;
        tc_s    = 1'b1;
      end else begin
        state_s = RUN;
      end
    end else if ((state_r == RUN) && cep && cet) begin
      if (count_r > ONE) begin
        count_s = count_r - ONE;
      end else begin
        // Expiry. A zero reload value cannot be reloaded, so it falls
        // back to one-shot behaviour.
        tc_s = 1'b1;
        if (mode && (rl_r != ZERO)) begin
          count_s = rl_r;
        end else begin
          count_s = ZERO;
          state_s = DONE;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  assign q    = count_r;
  assign tc   = tc_r;
  assign busy = (state_r == RUN);

endmodule
